slot_alloc: RTL
===============

// Module: slot_alloc
//
// PURPOSE
// - Round-robin allocator for W tag/slot IDs shared by one allocating and one freeing client.
// - Holds a busy vector and a search pointer, and offers the first free slot at or after the pointer, wrapping circularly.
// - Sits between the request front-end (tag consumer) and the completion path (tag returner).
// - The circular search is built from the existing bs, pri and enc primitives.
//
// PARAMETERS
// - W   32   number of slots; power of two, W >= 2.
//
// PORTS
// - clk           in   1           clock; all state updates on rising edge.
// - rst           in   1           synchronous, active-high reset.
// - flush_i       in   1           synchronous clear of all allocation state.
// - alloc_vld_o   out  1           a free slot is offered this cycle.
// - alloc_rdy_i   in   1           allocator client accepts the offered slot.
// - alloc_id_o    out  $clog2(W)   offered slot ID; meaningful only when alloc_vld_o=1.
// - free_vld_i    in   1           return a slot this cycle.
// - free_id_i     in   $clog2(W)   slot being returned.
// - count_o       out  $clog2(W)+1 number of busy slots, range 0..W.
// - full_o        out  1           all W slots busy.
// - err_o         out  1           one-cycle pulse: illegal free (slot not busy).
//
// BEHAVIOUR
// - State: busy_r[W-1:0], ptr_r[$clog2(W)-1:0], count_r, err_r.
// - Reset (rst=1): busy_r=0, ptr_r=0, count_r=0, err_r=0.
//   Outputs after reset: alloc_vld_o=1, alloc_id_o=0, count_o=0, full_o=0, err_o=0.
// - Search: alloc_id_o = smallest k in 0..W-1 with busy_r[(ptr_r+k) mod W]==0; the ID reported is (ptr_r+k) mod W.
// - Search is combinational from registered state only; no input-to-alloc_id_o path.
// - alloc_vld_o = ~full_o & ~flush_i.
// - Accept: alloc_vld_o & alloc_rdy_i.
//   - Next edge: busy_r[alloc_id_o]<=1 and ptr_r<=(alloc_id_o+1) mod W.
//   - ptr_r wraps W-1 -> 0.
// - ptr_r changes only on accept or reset/flush; a free never moves ptr_r.
// - Valid free (busy_r[free_id_i]==1): next edge busy_r[free_id_i]<=0.
//   - No bypass: a freed slot is first offerable the cycle after the free.
// - Illegal free (busy_r[free_id_i]==0): busy_r is unchanged and err_o=1 next cycle for exactly one cycle.
// - Accept and valid free in the same cycle:
//   - Both take effect.
//   - The IDs necessarily differ, because the offered slot is free.
//   - count_r is unchanged.
// - count_r: +1 on accept only, -1 on valid free only, unchanged on both or neither.
// - count_o=count_r; full_o=(count_r==W), equivalently busy_r all ones.
// - Full: alloc_vld_o=0 and alloc_rdy_i is ignored; frees still accepted.
// - Empty: offered ID = ptr_r.
// - flush_i=1, priority over alloc and free:
//   - next edge busy_r=0, ptr_r=0, count_r=0;
//   - alloc_vld_o=0 that cycle, so no handshake completes;
//   - free ignored and no err.
// - rst mid-operation: all state lost, same as flush. Outstanding IDs are invalid; clients must discard them.
// - rst has priority over flush_i.
// - Assertions:
//   - count_r == popcount(busy_r);
//   - alloc_vld_o -> ~busy_r[alloc_id_o];
//   - no X on outputs after reset.
//
// TESTING (W=8 unless stated)
// - Reset, rdy=1 for 8 cycles:
//   - IDs 0,1..7 in order;
//   - then full_o=1, alloc_vld_o=0, count_o=8.
// - Full, then free id 5:
//   - next cycle alloc_vld_o=1, alloc_id_o=5, count_o=7;
//   - accept gives ptr_r=6.
// - Round-robin: busy={0..3}, ptr_r=4; free 1 and 2 (separate cycles), alloc_rdy_i=1:
//   - offers 4,5,6,7,1,2;
//   - never 1 before 7.
// - Wrap: busy={6,7,0}, ptr_r=6 -> alloc_id_o=1; accept -> ptr_r=2.
// - Same-cycle accept of id 3 plus free of busy id 0:
//   - count_o unchanged;
//   - busy_r[3]=1 and busy_r[0]=0 next cycle.
// - Illegal free of id 4 while idle -> err_o=1 for one cycle; busy_r and count_o unchanged.
// - flush_i asserted with alloc_rdy_i=1 and free_vld_i=1:
//   - no accept;
//   - next cycle count_o=0, alloc_id_o=0.
// - Random soak, W=32: reference model compares alloc_id_o, count_o and err_o every cycle for 100k cycles.

Source files
------------

// File: rtl/slot_alloc.sv
// Round-robin slot/tag allocator. It tracks which slots are busy and offers the
// first free slot at or after a search pointer, wrapping circularly. The search
// runs in three stages: a barrel rotate by the pointer, a lowest-set-bit pick,
// and an encoder.
module slot_alloc #(
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    output logic                 alloc_vld_o,
    input  logic                 alloc_rdy_i,
    output logic [$clog2(W)-1:0] alloc_id_o,
    input  logic                 free_vld_i,
    input  logic [$clog2(W)-1:0] free_id_i,
    output logic [$clog2(W):0]   count_o,
    output logic                 full_o,
    output logic                 err_o
);
    localparam int IW = $clog2(W);

    logic [W-1:0]  busy_r;
    logic [IW-1:0] ptr_r;
    logic [IW:0]   count_r;
    logic          err_r;

    logic [W-1:0]  free_rot;
    logic [W-1:0]  first_hot;
    logic [IW-1:0] offset;
    logic          accept;
    logic          free_ok;

    // Rotation (bs): bit k of free_rot is slot ptr_r+k, so bit 0 is the pointer slot.
    always_comb begin
        free_rot = '0;
        for (int k = 0; k < W; k++) begin
            free_rot[k] = ~busy_r[ptr_r + IW'(k)];
        end
    end

    // Priority (pri): isolate the lowest free bit, i.e. the nearest free slot from ptr_r.
    assign first_hot = free_rot & (~free_rot + W'(1));

    // Encoder (enc): convert the one-hot pick into a distance from ptr_r.
    always_comb begin
        offset = '0;
        for (int k = 0; k < W; k++) begin
            if (first_hot[k]) offset = offset | IW'(k);
        end
    end

    // Power-of-two W lets the add wrap modulo W by truncation.
    assign alloc_id_o  = ptr_r + offset;
    assign full_o      = (count_r == (IW+1)'(W));
    assign alloc_vld_o = ~full_o & ~flush_i;
    assign count_o     = count_r;
    assign err_o       = err_r;

    assign accept  = alloc_vld_o & alloc_rdy_i;
    assign free_ok = free_vld_i & busy_r[free_id_i];

    // State update. rst wins over flush, and flush wins over alloc and free.
    // The offered slot is always free and the freed slot is always busy,
    // so the two busy_r bit writes below never target the same bit.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            busy_r  <= '0;
            ptr_r   <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (accept) begin
                busy_r[alloc_id_o] <= 1'b1;
                ptr_r              <= alloc_id_o + IW'(1);
            end
            if (free_ok) begin
                busy_r[free_id_i] <= 1'b0;
            end
            case ({accept, free_ok})
                2'b10:   count_r <= count_r + (IW+1)'(1);
                2'b01:   count_r <= count_r - (IW+1)'(1);
                default: count_r <= count_r;
            endcase
            err_r <= free_vld_i & ~busy_r[free_id_i];
        end
    end

    // The counter must always match the busy vector.
    a_count_pop: assert property (@(posedge clk) disable iff (rst)
        count_r == (IW+1)'($countones(busy_r)));

    // A valid offer must never name a busy slot.
    a_offer_free: assert property (@(posedge clk) disable iff (rst)
        alloc_vld_o |-> !busy_r[alloc_id_o]);

    // Once out of reset, every output is fully defined.
    a_no_x: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({alloc_vld_o, alloc_id_o, count_o, full_o, err_o}));

endmodule
